param_fifo: RTL and testbench
=============================

PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH_LOG2, default 3, log2 of entry count; DEPTH = 2**DEPTH_LOG2 (>=2 entries).
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, almost_full threshold in entries.
REQ-004 SHALL have parameter AE_LEVEL, default 1, almost_empty threshold in entries.
REQ-005 SHALL have parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-006 SHALL have one clock; reset is asynchronous and active-low: ports clk (input, 1, rising-edge clock) and nrst (input, 1, async active-low reset).
REQ-007 SHALL have ports: push input 1 write request; pop input 1 read request; data_in input WIDTH write data.
REQ-008 SHALL have ports: clr_err input 1 synchronous clear of error flags; data_out output WIDTH read data.
REQ-009 SHALL have ports: full output 1; empty output 1; almost_full output 1; almost_empty output 1.
REQ-010 SHALL have ports: count output DEPTH_LOG2+1 occupied entries; overflow output 1 sticky; underflow output 1 sticky.

Function
REQ-011 SHALL store up to DEPTH entries, using all DEPTH locations, with read/write pointers of DEPTH_LOG2+1 bits (extra wrap bit).
REQ-012 SHALL assert full when count == DEPTH and empty when count == 0, both derived combinationally from the registered pointers.
REQ-013 SHALL assert almost_full when count >= AF_LEVEL and almost_empty when count <= AE_LEVEL.
REQ-014 SHALL accept a pop (pop_ok) iff pop && !empty.
REQ-015 SHALL accept a push (push_ok) iff push && (!full || pop_ok); push while full with a simultaneous pop is accepted.
REQ-016 SHALL write data_in to the write location and advance the write pointer by 1 (modulo 2**(DEPTH_LOG2+1)) on each rising edge with push_ok.
REQ-017 SHALL advance the read pointer by 1, with the same modulo, on each rising edge with pop_ok.
REQ-018 SHALL update count +1 on push_ok only, -1 on pop_ok only, unchanged when both or neither; count never exceeds DEPTH or goes below 0.
REQ-019 SHALL, with FWFT=0, load data_out with the head entry on the edge of pop_ok (one-cycle latency) and hold it otherwise.
REQ-020 SHALL, with FWFT=1, drive data_out combinationally with the head entry when !empty and all zeros when empty; pop acknowledges the shown word.
REQ-021 SHALL, on simultaneous push_ok and pop_ok with empty deasserted, return the prior head and store the new word, including when full.
REQ-022 SHALL, on push while empty with pop asserted, accept the push, reject the pop, and set underflow.
REQ-023 SHALL set overflow on any edge where push && !push_ok, and underflow on any edge where pop && empty.
REQ-024 SHALL hold overflow/underflow until a clr_err edge; clr_err clears them, and a new error on the same edge takes priority (flag stays set).
REQ-025 SHALL leave stored data and pointers unchanged on rejected operations.

Reset
REQ-026 SHALL, on nrst low, immediately and asynchronously clear both pointers, count, overflow, underflow, and FWFT=0 data_out.
REQ-027 SHALL, while in reset, output empty=1, full=0, almost_empty=1, almost_full=0, and count=0.
REQ-028 SHALL not reset the storage array; contents after reset are not observable through data_out.
REQ-029 SHALL discard all stored entries when reset asserts mid-operation, and ignore push/pop while nrst is low.

Verification (WIDTH=8, DEPTH_LOG2=3, AF_LEVEL=6, AE_LEVEL=1)
REQ-030 SHALL check fill: push 0x01..0x08 from reset -> almost_full at count 6; full=1 and count=8 after the 8th; 9th push 0xFF sets overflow and is not stored.
REQ-031 SHALL check drain, FWFT=0: pop 8 times after fill -> data_out 0x01..0x08, each one cycle after its pop; empty=1; a 9th pop sets underflow with data_out held at 0x08.
REQ-032 SHALL check full push+pop: when full, push 0xAA with pop in the same cycle -> data_out=0x01, count stays 8, no overflow; 0xAA drains last.
REQ-033 SHALL check FWFT=1 with empty FIFO: push 0x5A -> data_out=0x5A the cycle after the push edge, with no pop; data_out=0x00 when empty.
REQ-034 SHALL check wrap: 20 interleaved push/pop cycles with a 3-deep backlog -> in-order data, count correct through pointer wrap.
REQ-035 SHALL check reset: drop nrst mid-burst with count=5 -> all outputs hit reset values without a clock edge; set overflow then pulse clr_err -> overflow=0.

Source files
------------

// File: rtl/param_fifo.sv
// Parameterised synchronous FIFO with registered or first-word-fall-through read,
// programmable almost-full/almost-empty thresholds and sticky error flags.
module param_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 3,
  parameter int AF_LEVEL   = (1 << DEPTH_LOG2) - 2,
  parameter int AE_LEVEL   = 1,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      data_in,
  input  logic                  clr_err,
  output logic [WIDTH-1:0]      data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int          CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_wptr;
  logic [CW-1:0]    r_rptr;
  logic             r_ovf;
  logic             r_unf;

  logic [CW-1:0]    w_count;
  logic             w_empty;
  logic             w_full;
  logic             w_pop_ok;
  logic             w_push_ok;
  logic [WIDTH-1:0] w_head;

  // Occupancy is the pointer difference; the extra wrap bit separates full from empty.
  assign w_count   = r_wptr - r_rptr;
  assign w_empty   = (w_count == '0);
  assign w_full    = (w_count == DEPTH_C);
  assign w_pop_ok  = pop && !w_empty;
  assign w_push_ok = push && (!w_full || w_pop_ok);
  assign w_head    = r_mem[r_rptr[DEPTH_LOG2-1:0]];

  assign count        = w_count;
  assign empty        = w_empty;
  assign full         = w_full;
  assign almost_full  = (w_count >= AF_C);
  assign almost_empty = (w_count <= AE_C);
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

  always_ff @(posedge clk) begin
    if (w_push_ok && nrst) begin
      r_mem[r_wptr[DEPTH_LOG2-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
      // A fresh error on the clearing edge wins over clr_err.
      r_ovf <= (clr_err ? 1'b0 : r_ovf) | (push && !w_push_ok);
      r_unf <= (clr_err ? 1'b0 : r_unf) | (pop && w_empty);
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = w_empty ? '0 : w_head;
    end else begin : g_reg
      logic [WIDTH-1:0] r_dout;
      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          r_dout <= '0;
        end else if (w_pop_ok) begin
          r_dout <= w_head;
        end
      end
      assign data_out = r_dout;
    end
  endgenerate

endmodule

// File: tb/tb_param_fifo.sv
// Directed self-checking bench for param_fifo: one registered-read instance and
// one first-word-fall-through instance sharing clock and reset.
module tb_param_fifo;

  logic       clk;
  logic       nrst;
  logic       push0, pop0, clr0;
  logic [7:0] din0, dout0;
  logic       full0, empty0, af0, ae0, ovf0, unf0;
  logic [3:0] count0;
  logic       push1, pop1, clr1;
  logic [7:0] din1, dout1;
  logic       full1, empty1, af1, ae1, ovf1, unf1;
  logic [3:0] count1;

  int n_chk;
  int n_err;

  param_fifo #(.WIDTH(8), .DEPTH_LOG2(3), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(0)) u_dut0 (
    .clk(clk), .nrst(nrst), .push(push0), .pop(pop0), .data_in(din0), .clr_err(clr0),
    .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .count(count0), .overflow(ovf0), .underflow(unf0)
  );

  param_fifo #(.WIDTH(8), .DEPTH_LOG2(3), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(1)) u_dut1 (
    .clk(clk), .nrst(nrst), .push(push1), .pop(pop1), .data_in(din1), .clr_err(clr1),
    .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .count(count1), .overflow(ovf1), .underflow(unf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Status of the registered-read instance for an expected occupancy.
  task automatic st0(input string tag, input int c);
    chk({tag, ".count"}, 32'(count0), 32'(c));
    chk({tag, ".empty"}, 32'(empty0), 32'(c == 0));
    chk({tag, ".full"},  32'(full0),  32'(c == 8));
    chk({tag, ".af"},    32'(af0),    32'(c >= 6));
    chk({tag, ".ae"},    32'(ae0),    32'(c <= 1));
  endtask

  task automatic cyc0(input logic p, input logic q, input logic [7:0] d, input logic c);
    @(negedge clk);
    push0 = p; pop0 = q; din0 = d; clr0 = c;
    @(posedge clk);
    #1;
    push0 = 1'b0; pop0 = 1'b0; clr0 = 1'b0;
  endtask

  task automatic cyc1(input logic p, input logic q, input logic [7:0] d);
    @(negedge clk);
    push1 = p; pop1 = q; din1 = d;
    @(posedge clk);
    #1;
    push1 = 1'b0; pop1 = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    nrst = 1'b0;
    push0 = 1'b0; pop0 = 1'b0; clr0 = 1'b0; din0 = '0;
    push1 = 1'b0; pop1 = 1'b0; clr1 = 1'b0; din1 = '0;
    repeat (2) @(posedge clk);
    #1;
    st0("rst", 0);
    chk("rst.dout0", 32'(dout0), 32'h0);
    chk("rst.ovf0",  32'(ovf0),  32'h0);
    chk("rst.unf0",  32'(unf0),  32'h0);
    chk("rst.dout1", 32'(dout1), 32'h0);
    chk("rst.empty1", 32'(empty1), 32'h1);
    @(negedge clk);
    nrst = 1'b1;

    // Fill 0x01..0x08, then one push too many.
    for (int i = 1; i <= 8; i++) begin
      cyc0(1'b1, 1'b0, 8'(i), 1'b0);
      st0("fill", i);
    end
    chk("fill.dout_nopop", 32'(dout0), 32'h0);
    cyc0(1'b1, 1'b0, 8'hFF, 1'b0);
    st0("ovf", 8);
    chk("ovf.flag", 32'(ovf0), 32'h1);

    // Drain: each word appears right after its pop edge.
    for (int i = 1; i <= 8; i++) begin
      cyc0(1'b0, 1'b1, 8'h00, 1'b0);
      chk("drain.dout", 32'(dout0), 32'(i));
      st0("drain", 8 - i);
    end
    cyc0(1'b0, 1'b1, 8'h00, 1'b0);
    chk("unf.flag", 32'(unf0), 32'h1);
    chk("unf.dout_held", 32'(dout0), 32'h08);
    st0("unf", 0);
    cyc0(1'b0, 1'b0, 8'h00, 1'b1);
    chk("clr.ovf", 32'(ovf0), 32'h0);
    chk("clr.unf", 32'(unf0), 32'h0);

    // Push+pop while full.
    for (int i = 1; i <= 8; i++) cyc0(1'b1, 1'b0, 8'(i), 1'b0);
    st0("refill", 8);
    cyc0(1'b1, 1'b1, 8'hAA, 1'b0);
    chk("fullpp.dout", 32'(dout0), 32'h01);
    chk("fullpp.ovf", 32'(ovf0), 32'h0);
    st0("fullpp", 8);
    for (int i = 2; i <= 8; i++) begin
      cyc0(1'b0, 1'b1, 8'h00, 1'b0);
      chk("drain2.dout", 32'(dout0), 32'(i));
    end
    cyc0(1'b0, 1'b1, 8'h00, 1'b0);
    chk("drain2.last", 32'(dout0), 32'hAA);
    st0("drain2", 0);

    // Push with pop while empty: push taken, pop refused.
    cyc0(1'b1, 1'b1, 8'h33, 1'b0);
    st0("emptypp", 1);
    chk("emptypp.unf", 32'(unf0), 32'h1);
    chk("emptypp.dout", 32'(dout0), 32'hAA);
    cyc0(1'b0, 1'b1, 8'h00, 1'b0);
    chk("emptypp.pop", 32'(dout0), 32'h33);
    st0("emptypp2", 0);
    cyc0(1'b0, 1'b1, 8'h00, 1'b1);
    chk("clrprio.unf", 32'(unf0), 32'h1);
    cyc0(1'b0, 1'b0, 8'h00, 1'b1);
    chk("clr2.unf", 32'(unf0), 32'h0);

    // Wrap with a steady backlog of three.
    for (int i = 0; i < 3; i++) cyc0(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc0(1'b1, 1'b1, 8'(8'h43 + i), 1'b0);
      chk("wrap.dout", 32'(dout0), 32'(8'h40 + i));
      chk("wrap.count", 32'(count0), 32'd3);
    end
    for (int i = 0; i < 3; i++) begin
      cyc0(1'b0, 1'b1, 8'h00, 1'b0);
      chk("wrap.tail", 32'(dout0), 32'(8'h54 + i));
    end
    st0("wrap.end", 0);

    // Asynchronous reset mid-burst.
    cyc0(1'b0, 1'b1, 8'h00, 1'b0);
    chk("pre_rst.unf", 32'(unf0), 32'h1);
    for (int i = 0; i < 5; i++) cyc0(1'b1, 1'b0, 8'(8'h60 + i), 1'b0);
    st0("burst", 5);
    @(negedge clk);
    push0 = 1'b1; din0 = 8'h77;
    #2 nrst = 1'b0;
    #1;
    st0("async_rst", 0);
    chk("async_rst.dout", 32'(dout0), 32'h0);
    chk("async_rst.unf", 32'(unf0), 32'h0);
    chk("async_rst.ovf", 32'(ovf0), 32'h0);
    @(posedge clk);
    #1;
    st0("in_rst_push", 0);
    push0 = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    cyc0(1'b0, 1'b0, 8'h00, 1'b0);
    st0("post_rst", 0);

    for (int i = 1; i <= 8; i++) cyc0(1'b1, 1'b0, 8'(i), 1'b0);
    cyc0(1'b1, 1'b0, 8'hEE, 1'b0);
    chk("ovf2.flag", 32'(ovf0), 32'h1);
    cyc0(1'b0, 1'b0, 8'h00, 1'b1);
    chk("ovf2.clr", 32'(ovf0), 32'h0);
    st0("ovf2", 8);

    // First-word-fall-through instance.
    chk("fwft.empty_dout", 32'(dout1), 32'h0);
    cyc1(1'b1, 1'b0, 8'h5A);
    chk("fwft.show", 32'(dout1), 32'h5A);
    chk("fwft.empty", 32'(empty1), 32'h0);
    cyc1(1'b1, 1'b0, 8'h6B);
    chk("fwft.hold", 32'(dout1), 32'h5A);
    chk("fwft.count", 32'(count1), 32'd2);
    cyc1(1'b0, 1'b1, 8'h00);
    chk("fwft.next", 32'(dout1), 32'h6B);
    cyc1(1'b0, 1'b1, 8'h00);
    chk("fwft.drained", 32'(dout1), 32'h0);
    chk("fwft.empty2", 32'(empty1), 32'h1);
    cyc1(1'b0, 1'b1, 8'h00);
    chk("fwft.unf", 32'(unf1), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
